spi_sensor_responder: RTL and testbench
=======================================

// Module: spi_sensor_responder
// PURPOSE
//  SPI target (mode 3: SCK idles high, CS active low, MSB first) that models the humidity/pressure
//  sensor at the far end of the sensor SPI link. Decodes {rw,addr[6:0]} command byte, serves reads
//  from a small register map, accepts writes to control registers. Used as bench/FPGA stand-in sensor.
// PARAMETERS
//  CHIP_ID     8'h60   value returned at addr 7'h50
//  SYNC_STAGES 2       synchronizer depth on sck/cs/mosi (>=2)
// PORTS
//  clk        in  1   system clock
//  reset      in  1   synchronous, active-high reset
//  sck        in  1   SPI clock from initiator (async to clk)
//  cs         in  1   chip select, active low (async)
//  mosi       in  1   initiator->target data (async)
//  miso       out 1   target->initiator data
//  miso_oe    out 1   1 while target drives miso (read data phase only)
//  meas_data  in  64  raw measurement bytes, [63:56]=addr 7'h77 ... [7:0]=addr 7'h7E
//  meas_valid in  1   1-clk strobe: new meas_data available
//  busy       in  1   measuring flag, reported as status bit 3
//  ctrl_hum   out 3   reg 7'h72 [2:0]
//  ctrl_meas  out 8   reg 7'h74
//  config_reg out 8   reg 7'h75
//  wr_strobe  out 1   1-clk pulse on every accepted register write
//  wr_addr    out 7   address of last accepted write
//  wr_data    out 8   data of last accepted write
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; shadow meas regs 0; pending flag 0.
//  - sck/cs/mosi pass SYNC_STAGES flops; edges detected on synced sck. Legal sck half-period >= 4 clk.
//  - Sampling on sck rising edge; miso changes only on sck falling edge, within SYNC_STAGES+1 clk.
//  - FSM: IDLE -> ADDR on cs falling; ADDR shifts 8 bits; after 8th rising edge: bit7=1 -> RD_DATA,
//    bit7=0 -> WR_DATA. cs high (synced) in any state -> IDLE same cycle; partial byte discarded,
//    no write committed, miso_oe<=0, miso<=0.
//  - RD_DATA: register value loaded at 8th rising edge of previous byte; bit7 on miso at next falling
//    edge, remaining bits on following falling edges. miso_oe=1 from first data falling edge to cs high.
//  - WR_DATA: after 8th rising edge of data byte, writable target updated; wr_strobe=1 next clk with
//    wr_addr/wr_data. Writes to read-only/unmapped addr: no register change, no wr_strobe.
//  - Map: 7'h50 CHIP_ID (RO); 7'h72 ctrl_hum [2:0] (RW, bits 7:3 read 0); 7'h73 status {4'b0,busy,3'b0}
//    (RO); 7'h74 ctrl_meas (RW); 7'h75 config_reg (RW); 7'h77..7'h7E shadow meas bytes (RO);
//    all other addresses read 8'h00.
//  - Shadow: meas_valid while cs high -> shadow <= meas_data next clk. meas_valid while cs low ->
//    latch into pending buffer, copy to shadow on cs rising (burst reads stay coherent). Second strobe
//    during same transaction overwrites pending buffer (latest wins).
//  - Address counter 7-bit, wraps 7'h7F -> 7'h00.
// CONFIGURATION
//  SPI_RESP_BURST_EN defined: after each data byte address auto-increments, RD_DATA/WR_DATA repeat
//    until cs high (burst read/write).
//  Undefined: exactly one data byte per transaction; further bytes: reads shift out 8'hFF,
//    writes ignored (no wr_strobe), until cs high.
// TESTING
//  1 reset, cs high -> all outputs 0, miso_oe=0; read 0x50 (cmd 8'hD0) -> miso byte 8'h60.
//  2 write cmd 8'h74 + 8'h27 -> ctrl_meas=8'h27, one wr_strobe, wr_addr=7'h74; readback 8'hF4 -> 8'h27.
//  3 write 8'h72 + 8'hFF -> ctrl_hum=3'b111, read returns 8'h07; write 8'h50 + 8'h00 -> no strobe.
//  4 meas_data=64'h0123456789ABCDEF, meas_valid, burst read 8'hF7 x8 (BURST_EN) -> 01,23,...,EF;
//    without BURST_EN -> 01,FF,FF,...
//  5 meas_valid with new value mid-burst -> remaining bytes old value; next transaction new value.
//  6 cs high after 5 bits of write data to 8'h75 -> config_reg unchanged, no wr_strobe, FSM IDLE;
//    reset asserted mid-read -> miso_oe=0 next clk.

Source files
------------

// File: rtl/spi_sensor_responder_if.sv
// SPI link between an initiator (master) and the emulated sensor target (slave).
interface spi_sensor_responder_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output cs, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sensor_responder.sv
// Mode-3 SPI target emulating a humidity/pressure sensor register map.
// Optional feature macro SPI_RESP_BURST_EN: auto-increment burst reads/writes until cs rises.
module spi_sensor_responder #(
  parameter logic [7:0] CHIP_ID     = 8'h60,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  spi_sensor_responder_if.slave spi,
  input  logic [63:0]           meas_data,
  input  logic                  meas_valid,
  input  logic                  busy,
  output logic [2:0]            ctrl_hum,
  output logic [7:0]            ctrl_meas,
  output logic [7:0]            config_reg,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data
);

  typedef enum logic [2:0] {IDLE, ADDR, RD_DATA, WR_DATA, DRAIN} state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic        sck_s, cs_s, mosi_s;
  logic        sck_prev, cs_prev;
  logic        sck_rise, sck_fall, cs_fall, cs_rise;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  shift_out;
  logic [6:0]  addr;
  logic        rd_mode;
  logic [7:0]  rx_byte;
  logic [63:0] shadow;
  logic [63:0] pending;
  logic        pending_flag;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_fall  = ~cs_s & cs_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign rx_byte  = {shift_in, mosi_s};

  // Idle levels (sck and cs high) are the reset value so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '1;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  function automatic logic [7:0] read_reg(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      7'h50:   v = CHIP_ID;
      7'h72:   v = {5'b0, ctrl_hum};
      7'h73:   v = {4'b0, busy, 3'b0};
      7'h74:   v = ctrl_meas;
      7'h75:   v = config_reg;
      7'h77:   v = shadow[63:56];
      7'h78:   v = shadow[55:48];
      7'h79:   v = shadow[47:40];
      7'h7A:   v = shadow[39:32];
      7'h7B:   v = shadow[31:24];
      7'h7C:   v = shadow[23:16];
      7'h7D:   v = shadow[15:8];
      7'h7E:   v = shadow[7:0];
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Rising and falling sck edges never coincide, so shifting out and reloading cannot collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift_in   <= 7'd0;
      shift_out  <= 8'd0;
      addr       <= 7'd0;
      rd_mode    <= 1'b0;
      spi.miso   <= 1'b0;
      spi.miso_oe <= 1'b0;
      ctrl_hum   <= 3'd0;
      ctrl_meas  <= 8'd0;
      config_reg <= 8'd0;
      wr_strobe  <= 1'b0;
      wr_addr    <= 7'd0;
      wr_data    <= 8'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (cs_s) begin
        state       <= IDLE;
        bit_cnt     <= 3'd0;
        spi.miso    <= 1'b0;
        spi.miso_oe <= 1'b0;
      end else begin
        if (sck_fall && (state == RD_DATA || (state == DRAIN && rd_mode))) begin
          spi.miso    <= shift_out[7];
          spi.miso_oe <= 1'b1;
          shift_out   <= {shift_out[6:0], 1'b1};
        end
        if (state == IDLE) begin
          if (cs_fall) begin
            state   <= ADDR;
            bit_cnt <= 3'd0;
          end
        end else if (sck_rise) begin
          shift_in <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              ADDR: begin
                addr    <= rx_byte[6:0];
                rd_mode <= rx_byte[7];
                if (rx_byte[7]) begin
                  state     <= RD_DATA;
                  shift_out <= read_reg(rx_byte[6:0]);
                end else begin
                  state <= WR_DATA;
                end
              end
              RD_DATA: begin
`ifdef SPI_RESP_BURST_EN
                addr      <= addr + 7'd1;
                shift_out <= read_reg(addr + 7'd1);
`else
                state     <= DRAIN;
                shift_out <= 8'hFF;
`endif
              end
              WR_DATA: begin
                if (addr == 7'h72 || addr == 7'h74 || addr == 7'h75) begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                  wr_data   <= rx_byte;
                  case (addr)
                    7'h72:   ctrl_hum   <= rx_byte[2:0];
                    7'h74:   ctrl_meas  <= rx_byte;
                    default: config_reg <= rx_byte;
                  endcase
                end
`ifdef SPI_RESP_BURST_EN
                addr <= addr + 7'd1;
`else
                state <= DRAIN;
`endif
              end
              default: shift_out <= 8'hFF;
            endcase
          end
        end
      end
    end
  end

  // Updates arriving mid-transaction are parked until cs rises so burst reads stay coherent.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow       <= 64'd0;
      pending      <= 64'd0;
      pending_flag <= 1'b0;
    end else begin
      if (cs_rise && pending_flag) begin
        shadow       <= pending;
        pending_flag <= 1'b0;
      end
      if (meas_valid) begin
        if (cs_s) begin
          shadow <= meas_data;
        end else begin
          pending      <= meas_data;
          pending_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Self-checking bench for spi_sensor_responder: mode-3 SPI initiator plus byte scoreboard.
module tb_spi_sensor_responder;
  localparam int HALF = 80;
`ifdef SPI_RESP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] meas_data;
  logic        meas_valid;
  logic        busy;
  logic [2:0]  ctrl_hum;
  logic [7:0]  ctrl_meas;
  logic [7:0]  config_reg;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  int          n_checks = 0;
  int          n_fail = 0;
  int          strobe_cnt = 0;
  logic [6:0]  last_wr_addr = 7'd0;
  logic [7:0]  last_wr_data = 8'd0;
  logic        last_oe;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];

  spi_sensor_responder_if bus();

  spi_sensor_responder #(.CHIP_ID(8'h60), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .spi(bus),
    .meas_data(meas_data), .meas_valid(meas_valid), .busy(busy),
    .ctrl_hum(ctrl_hum), .ctrl_meas(ctrl_meas), .config_reg(config_reg),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Observe every write pulse so tests can count strobes and see the last committed write.
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      last_wr_addr = wr_addr;
      last_wr_data = wr_data;
    end
  end

  function automatic logic [7:0] meas_byte(input logic [63:0] v, input int k);
    return v[63-8*k -: 8];
  endfunction

  task automatic spi_begin();
    bus.cs = 1'b0;
    #(HALF);
  endtask

  task automatic spi_end();
    bus.cs = 1'b1;
    #(2*HALF);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.sck  = 1'b0;
      bus.mosi = tx[i];
      #(HALF);
      bus.sck  = 1'b1;
      rx[i]    = bus.miso;
      #(HALF);
    end
  endtask

  task automatic spi_read(input logic [7:0] cmd, input int n);
    logic [7:0] rx;
    spi_begin();
    spi_byte(cmd, rx);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, rx);
      rx_q.push_back(rx);
    end
    last_oe = bus.miso_oe;
    spi_end();
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] rx;
    spi_begin();
    spi_byte(cmd, rx);
    spi_byte(data, rx);
    spi_end();
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.miso_oe !== 1'b0 || bus.miso !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_miso: oe=%b miso=%b, want 0/0", bus.miso_oe, bus.miso);
    end
    n_checks++;
    if ({ctrl_hum, ctrl_meas, config_reg} !== 19'd0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %h, want 0", {ctrl_hum, ctrl_meas, config_reg});
    end
    n_checks++;
    if ({wr_strobe, wr_addr, wr_data} !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_wr: got %h, want 0", {wr_strobe, wr_addr, wr_data});
    end
  endtask

  task automatic test_chip_id();
    exp_q.push_back(8'h60);
    spi_read(8'hD0, 1);
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("[TB] FAIL chip_id[%0d]: got %h, want %h", k, rx_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); rx_q.delete();
    n_checks++;
    if (last_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL oe_during_read: got %b, want 1", last_oe); end
    n_checks++;
    if (bus.miso_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL oe_after_cs: got %b, want 0", bus.miso_oe); end
  endtask

  task automatic test_write_readback();
    int s0;
    s0 = strobe_cnt;
    spi_write(8'h74, 8'h27);
    n_checks++;
    if (ctrl_meas !== 8'h27) begin n_fail++; $display("[TB] FAIL ctrl_meas: got %h, want 27", ctrl_meas); end
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("[TB] FAIL strobe_count: got %0d, want 1", strobe_cnt - s0); end
    n_checks++;
    if (last_wr_addr !== 7'h74 || last_wr_data !== 8'h27) begin
      n_fail++; $display("[TB] FAIL wr_addr_data: got %h/%h, want 74/27", last_wr_addr, last_wr_data);
    end
    exp_q.push_back(8'h27);
    spi_read(8'hF4, 1);
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("[TB] FAIL readback_74[%0d]: got %h, want %h", k, rx_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_ctrl_hum_and_ro();
    int s0;
    spi_write(8'h72, 8'hFF);
    n_checks++;
    if (ctrl_hum !== 3'b111) begin n_fail++; $display("[TB] FAIL ctrl_hum: got %b, want 111", ctrl_hum); end
    busy = 1'b1;
    exp_q.push_back(8'h07);
    spi_read(8'hF2, 1);
    exp_q.push_back(8'h08);
    spi_read(8'hF3, 1);
    busy = 1'b0;
    s0 = strobe_cnt;
    spi_write(8'h50, 8'h00);
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("[TB] FAIL ro_strobe: got %0d, want 0", strobe_cnt - s0); end
    exp_q.push_back(8'h60);
    spi_read(8'hD0, 1);
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("[TB] FAIL hum_status_id[%0d]: got %h, want %h", k, rx_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_multi_byte_write();
    int s0;
    logic [7:0] rx;
    logic [7:0] cfg_before;
    cfg_before = config_reg;
    s0 = strobe_cnt;
    spi_begin();
    spi_byte(8'h74, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    spi_end();
    n_checks++;
    if (ctrl_meas !== 8'h11) begin n_fail++; $display("[TB] FAIL multi_ctrl_meas: got %h, want 11", ctrl_meas); end
    n_checks++;
    if (config_reg !== (BURST ? 8'h22 : cfg_before)) begin
      n_fail++; $display("[TB] FAIL multi_config: got %h, want %h", config_reg, BURST ? 8'h22 : cfg_before);
    end
    n_checks++;
    if (strobe_cnt - s0 !== (BURST ? 2 : 1)) begin
      n_fail++; $display("[TB] FAIL multi_strobes: got %0d, want %0d", strobe_cnt - s0, BURST ? 2 : 1);
    end
  endtask

  task automatic test_meas_burst();
    logic [63:0] v;
    v = 64'h0123456789ABCDEF;
    @(negedge clk); meas_data = v; meas_valid = 1'b1;
    @(negedge clk); meas_valid = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back((BURST || k == 0) ? meas_byte(v, k) : 8'hFF);
    spi_read(8'hF7, 8);
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("[TB] FAIL meas_burst[%0d]: got %h, want %h", k, rx_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_mid_burst_update();
    logic [63:0] old_v, new_v;
    logic [7:0] rx;
    old_v = 64'h0123456789ABCDEF;
    new_v = 64'hFEDCBA9876543210;
    for (int k = 0; k < 8; k++) exp_q.push_back((BURST || k == 0) ? meas_byte(old_v, k) : 8'hFF);
    spi_begin();
    spi_byte(8'hF7, rx);
    for (int k = 0; k < 8; k++) begin
      spi_byte(8'h00, rx);
      rx_q.push_back(rx);
      if (k == 1) begin
        @(negedge clk); meas_data = new_v; meas_valid = 1'b1;
        @(negedge clk); meas_valid = 1'b0;
      end
    end
    spi_end();
    for (int k = 0; k < 8; k++) exp_q.push_back((BURST || k == 0) ? meas_byte(new_v, k) : 8'hFF);
    spi_read(8'hF7, 8);
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("[TB] FAIL mid_burst[%0d]: got %h, want %h", k, rx_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_abort_and_reset();
    int s0;
    logic [7:0] rx;
    spi_write(8'h75, 8'h3C);
    s0 = strobe_cnt;
    spi_begin();
    spi_byte(8'h75, rx);
    for (int i = 0; i < 5; i++) begin
      bus.sck = 1'b0; bus.mosi = 1'b1; #(HALF);
      bus.sck = 1'b1; #(HALF);
    end
    spi_end();
    n_checks++;
    if (config_reg !== 8'h3C) begin n_fail++; $display("[TB] FAIL abort_config: got %h, want 3c", config_reg); end
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("[TB] FAIL abort_strobe: got %0d, want 0", strobe_cnt - s0); end
    exp_q.push_back(8'h3C);
    spi_read(8'hF5, 1);
    spi_begin();
    spi_byte(8'hD0, rx);
    for (int i = 0; i < 3; i++) begin
      bus.sck = 1'b0; #(HALF);
      bus.sck = 1'b1; #(HALF);
    end
    n_checks++;
    if (bus.miso_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL oe_mid_read: got %b, want 1", bus.miso_oe); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.miso_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL oe_after_reset: got %b, want 0", bus.miso_oe); end
    bus.cs = 1'b1; bus.sck = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (config_reg !== 8'h00 || ctrl_meas !== 8'h00) begin
      n_fail++; $display("[TB] FAIL regs_after_reset: got %h/%h, want 00/00", config_reg, ctrl_meas);
    end
    exp_q.push_back(8'h60);
    spi_read(8'hD0, 1);
    foreach (exp_q[k]) begin
      n_checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        n_fail++; $display("[TB] FAIL abort_reads[%0d]: got %h, want %h", k, rx_q[k], exp_q[k]);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  initial begin
    reset = 1'b1; bus.cs = 1'b1; bus.sck = 1'b1; bus.mosi = 1'b0;
    meas_data = 64'd0; meas_valid = 1'b0; busy = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] starting, burst=%0d", BURST);
    test_reset();
    test_chip_id();
    test_write_readback();
    test_ctrl_hum_and_ro();
    test_multi_byte_write();
    test_meas_burst();
    test_mid_burst_update();
    test_abort_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
